// File: rtl/serial_add_sub_pkg.sv
// ============================================================================
//  Module      : serial_add_sub_pkg
//  Description : Shared definitions for the bit-serial adder/subtractor:
//                FSM state encoding and a ceiling-log2 helper used to size
//                the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_sub_pkg;

  // FSM state encoding (2-bit constants)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder cell.
//  Ports       : a_i, b_i, cin_i  - addend bits and carry-in
//                sum_o            - a ^ b ^ cin
//                cout_o           - majority(a, b, cin)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
//  Module      : serial_add_sub
//  Description : Bit-serial WIDTH-bit two's-complement adder/subtractor.
//                One bit per clock, LSB first, through a single full-adder
//                cell and a carry flip-flop.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start             - request operation (ignored while busy)
//                sub               - 0: A+B+Cin, 1: A-B-Cin (Cin = borrow)
//                A, B, Cin         - operands, captured on accepted start
//                busy              - high while bits are processed
//                done              - one-cycle pulse when results update
//                S, Cout, OVF      - result, carry/no-borrow, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int CNT_W = (CLOG2(WIDTH) < 1) ? 1 : CLOG2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from the cell
  // on the completion edge.
  logic [WIDTH-2:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  full_adder u_fa (
    .a_i    (opa_q[0]),
    .b_i    (opb_q[0]),
    .cin_i  (carry_q),
    .sum_o  (sum_d),
    .cout_o (carry_d)
  );

  assign res_d = {sum_d, res_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is A + ~B + ~borrow: invert B and the carry-in.
            opa_q   <= A;
            opb_q   <= sub ? ~B : B;
            carry_q <= sub ? ~Cin : Cin;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
          res_q   <= res_d[WIDTH-1:1];
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            s_q     <= res_d;
            cout_q  <= carry_d;
            // carry_q is the carry into the MSB on this edge.
            ovf_q   <= carry_q ^ carry_d;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign OVF  = ovf_q;

endmodule

`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial, WIDTH-bit two's-complement adder/subtractor, processing one bit per clock LSB-first through a single full-adder cell and a carry flip-flop.
- Parametrised sequential successor of the one-bit full adder cell.
- Used where area matters more than latency, e.g. datapath accumulators and lab ALU slices.
- Operands are captured on a start handshake; the result, carry-out and overflow are presented with a one-cycle done pulse and then held.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, only clock in the block
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- sub  input  1  mode select: 0 = A+B+Cin, 1 = A-B-Cin (Cin acts as borrow-in)
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse: result outputs just updated
- S  output  WIDTH  result, registered, held until next completion
- Cout  output  1  carry-out (add); for sub, 1 = no borrow
- OVF  output  1  signed overflow

Behaviour:
- States: IDLE, RUN, DONE. Encodings are 2-bit constants.
- Reset (synchronous, any state, including mid-RUN):
  - state = IDLE; busy = 0; done = 0; S = 0; Cout = 0; OVF = 0
  - bit counter = 0; internal shift registers and carry FF = 0
  - any in-flight operation is discarded.
- Accept rule: start = 1 at a rising edge while state is IDLE or DONE. start while in RUN is ignored, with no queueing.
- On accept:
  - opA = A; opB = sub ? ~B : B
  - carry FF = sub ? ~Cin : Cin
  - counter = 0; state goes to RUN.
- RUN, per edge:
  - sum bit = opA[0] ^ opB[0] ^ carry; new carry = majority(opA[0], opB[0], carry).
  - sum bit shifts into the MSB of the internal result register; opA and opB shift right by 1.
  - counter increments.
  - On the edge where counter == WIDTH-1 (the MSB bit):
    - S = completed result; Cout = new carry; OVF = carry-into-MSB ^ new carry
    - state goes to DONE.
- busy = 1 exactly when state == RUN. done = 1 exactly when state == DONE.
- DONE lasts one cycle, then the block returns to IDLE unless start is accepted in that cycle, in which case it goes straight to RUN (back-to-back, no dead cycle).
- Latency: start accepted at edge k means done = 1 in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- S, Cout and OVF change only at the completion edge or at reset. They stay stable during RUN of a subsequent operation.
- Inputs A, B, Cin and sub are don't-care outside the accepting edge.
- Widths:
  - counter is clog2(WIDTH) bits, minimum 1.
  - No arithmetic wider than 1 bit is performed. Everything beyond the single-bit cell is shifting and counting.

Decomposition:
- Shared include/package holds the state constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, and a CLOG2 helper function.
- Sub-module: instantiate the existing one-bit full_adder cell for the per-bit sum/carry, so the cell stays the single source of truth.
- FSM, counter, shift registers and carry FF live in the top module.

Test Plan:
- WIDTH=8, add, A=8'h35, B=8'h4A, Cin=0:
  - S=8'h7F, Cout=0, OVF=0
  - done exactly 8 cycles after the start edge, busy high for 8 cycles.
- Add, A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, OVF=0. Then A=8'h7F, B=8'h01 -> S=8'h80, Cout=0, OVF=1.
- Sub:
  - A=8'h05, B=8'h07, Cin=0 -> S=8'hFE, Cout=0 (borrow), OVF=0
  - A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, OVF=1
  - A=8'h10, B=8'h01, Cin=1 -> S=8'h0E.
- Start pulsed again 3 cycles into RUN with different operands -> ignored. The first result is delivered unchanged, and done occurs once.
- rst asserted at RUN cycle 4:
  - next cycle busy=0, done=0, S=0, Cout=0, OVF=0, no done pulse follows
  - a fresh start of 8'h35+8'h4A then completes correctly.
- Back-to-back: start held high continuously:
  - done pulses every 9 cycles
  - S updates only on done cycles and is stable in between.
- Repeat the first and third scenarios with WIDTH=2 and WIDTH=16 to check parametrisation.
